// File: rtl/mips_mc_pkg.sv
// Shared encodings for the MIPS multicycle control FSM: states, opcodes, functs and steering codes.
package mips_mc_pkg;

  localparam int unsigned ST_BITS = 4;

  typedef enum logic [ST_BITS-1:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_alu_dec.sv
// ALU decoder: maps the FSM's ALUOp class plus Funct onto the 3-bit ALUControl code.
import mips_mc_pkg::*;

module mips_mc_alu_dec (
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        // Unknown funct falls back to add; write-back still happens.
        case (funct)
          FN_SUB:  alu_control = ALU_SUB;
          FN_AND:  alu_control = ALU_AND;
          FN_OR:   alu_control = ALU_OR;
          FN_SLT:  alu_control = ALU_SLT;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Moore multicycle control FSM for the MIPS datapath (lw, sw, R-type, beq, addi, j).
// Define MIPS_MC_CTRL_BNE_EN to add bne (opcode 0x05) through the BRANCH state.
import mips_mc_pkg::*;

module mips_mc_control #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCen,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         PCsrc,
  output logic [STATE_W-1:0] state_o
);

  state_t     state, next_state;
  logic       pc_write, branch, taken;
  logic       ir_write_c, mem_write_c, reg_write_c;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

`ifdef MIPS_MC_CTRL_BNE_EN
  logic is_bne;

  // Remembers which branch flavour DECODE saw, since BRANCH no longer looks at Opcode.
  always_ff @(posedge clk) begin
    if (!reset)              is_bne <= 1'b0;
    else if (state == DECODE) is_bne <= (Opcode == OP_BNE);
  end

  assign taken = is_bne ? ~Zero : Zero;
`else
  assign taken = Zero;
`endif

  always_comb begin
    next_state  = FETCH;
    pc_write    = 1'b0;
    branch      = 1'b0;
    ir_write_c  = 1'b0;
    mem_write_c = 1'b0;
    reg_write_c = 1'b0;
    IorD        = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    alu_op      = ALUOP_ADD;
    PCsrc       = PCSRC_ALU;
    case (state)
      FETCH: begin
        next_state = DECODE;
        ALUSrcB    = SRCB_FOUR;
        ir_write_c = 1'b1;
        pc_write   = 1'b1;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        case (Opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = EXECUTE;
          OP_BEQ:       next_state = BRANCH;
`ifdef MIPS_MC_CTRL_BNE_EN
          OP_BNE:       next_state = BRANCH;
`endif
          OP_ADDI:      next_state = ADDIEXEC;
          OP_J:         next_state = JUMP;
          default:      next_state = FETCH;
        endcase
      end
      MEMADR, ADDIEXEC: begin
        next_state = (state == ADDIEXEC) ? ADDIWB
                   : ((Opcode == OP_SW) ? MEMWR : MEMRD);
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
      end
      MEMRD: begin
        next_state = MEMWB;
        IorD       = 1'b1;
      end
      MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_c = 1'b1;
      end
      MEMWR: begin
        IorD        = 1'b1;
        mem_write_c = 1'b1;
      end
      EXECUTE: begin
        next_state = ALUWB;
        ALUSrcA    = 1'b1;
        alu_op     = ALUOP_FUNCT;
      end
      ALUWB: begin
        RegDst      = 1'b1;
        reg_write_c = 1'b1;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCsrc   = PCSRC_ALUOUT;
        branch  = 1'b1;
      end
      ADDIWB: reg_write_c = 1'b1;
      JUMP: begin
        PCsrc    = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  mips_mc_alu_dec u_alu_dec (
    .alu_op      (alu_op),
    .funct       (Funct),
    .alu_control (ALUControl)
  );

  // Architectural writes are suppressed while reset is held so an aborted instruction leaves no trace.
  assign PCen     = reset & (pc_write | (branch & taken));
  assign IRWrite  = reset & ir_write_c;
  assign MemWrite = reset & mem_write_c;
  assign RegWrite = reset & reg_write_c;
  assign state_o  = STATE_W'(state);

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed bench for mips_mc_control: walks every instruction class, reset abort and the bne option.
`timescale 1ns/1ps
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       Zero;
  logic       PCen, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCsrc;
  logic [2:0] ALUControl;
  logic [3:0] state_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mips_mc_control #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCen(PCen), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .PCsrc(PCsrc), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; sample a little after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic step_state(input string tag, input logic [3:0] exp);
    tick();
    check(tag, 32'(state_o), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; Opcode = 6'h23; Funct = 6'h00; Zero = 1'b0;
    @(negedge clk);
    // Reset held three cycles with lw on the IR
    repeat (3) begin
      #1;
      check("rst_state", 32'(state_o), 32'd0);
      check("rst_wen", 32'({PCen, IRWrite, MemWrite, RegWrite}), 32'd0);
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check("fetch_pcen", 32'(PCen), 32'd1);
    check("fetch_irw", 32'(IRWrite), 32'd1);
    check("fetch_srcb", 32'(ALUSrcB), 32'b01);

    // lw: 0,1,2,3,4,0
    step_state("lw_dec", 4'd1);
    check("dec_srcb", 32'(ALUSrcB), 32'b11);
    step_state("lw_madr", 4'd2);
    check("madr_src", 32'({ALUSrcA, ALUSrcB}), 32'b110);
    step_state("lw_mrd", 4'd3);
    check("mrd_iord", 32'(IorD), 32'd1);
    step_state("lw_mwb", 4'd4);
    check("mwb_ctl", 32'({RegWrite, MemtoReg, RegDst}), 32'b110);
    step_state("lw_done", 4'd0);

    // R-type sub then slt
    Opcode = 6'h00; Funct = 6'h22;
    step_state("sub_dec", 4'd1);
    step_state("sub_ex", 4'd6);
    check("sub_aluc", 32'(ALUControl), 32'b110);
    check("ex_src", 32'({ALUSrcA, ALUSrcB}), 32'b100);
    step_state("sub_wb", 4'd7);
    check("alu_wb", 32'({RegDst, RegWrite, MemtoReg}), 32'b110);
    step_state("sub_done", 4'd0);
    Funct = 6'h2A;
    step_state("slt_dec", 4'd1);
    step_state("slt_ex", 4'd6);
    check("slt_aluc", 32'(ALUControl), 32'b111);
    step_state("slt_wb", 4'd7);
    step_state("slt_done", 4'd0);
    // Unknown funct: add, still writes back
    Funct = 6'h3F;
    step_state("unk_dec", 4'd1);
    step_state("unk_ex", 4'd6);
    check("unk_aluc", 32'(ALUControl), 32'b010);
    step_state("unk_wb", 4'd7);
    check("unk_regw", 32'(RegWrite), 32'd1);
    step_state("unk_done", 4'd0);

    // beq taken / not taken
    Opcode = 6'h04; Zero = 1'b1;
    step_state("beq1_dec", 4'd1);
    step_state("beq1_br", 4'd8);
    check("beq1_pcen", 32'(PCen), 32'd1);
    check("beq1_pcsrc", 32'(PCsrc), 32'b01);
    check("beq1_aluc", 32'(ALUControl), 32'b110);
    step_state("beq1_done", 4'd0);
    Zero = 1'b0;
    step_state("beq0_dec", 4'd1);
    step_state("beq0_br", 4'd8);
    check("beq0_pcen", 32'(PCen), 32'd0);
    step_state("beq0_done", 4'd0);

    // addi
    Opcode = 6'h08;
    step_state("addi_dec", 4'd1);
    check("addi_dec_rw", 32'(RegWrite), 32'd0);
    step_state("addi_ex", 4'd9);
    check("addi_ex_rw", 32'(RegWrite), 32'd0);
    check("addi_ex_srcb", 32'(ALUSrcB), 32'b10);
    step_state("addi_wb", 4'd10);
    check("addi_wb_ctl", 32'({RegWrite, RegDst, MemtoReg}), 32'b100);
    step_state("addi_done", 4'd0);

    // j
    Opcode = 6'h02;
    step_state("j_dec", 4'd1);
    step_state("j_jump", 4'd11);
    check("j_pcen", 32'(PCen), 32'd1);
    check("j_pcsrc", 32'(PCsrc), 32'b10);
    step_state("j_done", 4'd0);

    // Illegal opcode: 2-cycle NOP
    Opcode = 6'h3F;
    step_state("ill_dec", 4'd1);
    step_state("ill_done", 4'd0);

    // bne
    Opcode = 6'h05; Zero = 1'b0;
    step_state("bne_dec", 4'd1);
`ifdef MIPS_MC_CTRL_BNE_EN
    step_state("bne_br", 4'd8);
    check("bne_pcen_z0", 32'(PCen), 32'd1);
    Zero = 1'b1;
    #1;
    check("bne_pcen_z1", 32'(PCen), 32'd0);
`endif
    step_state("bne_done", 4'd0);

    // sw aborted by reset in MEMWR, then a complete sw
    Opcode = 6'h2B; Zero = 1'b0;
    step_state("swa_dec", 4'd1);
    step_state("swa_madr", 4'd2);
    step_state("swa_mwr", 4'd5);
    check("swa_memw", 32'({MemWrite, IorD}), 32'b11);
    reset = 1'b0;
    #1;
    check("swa_rst_memw", 32'(MemWrite), 32'd0);
    step_state("swa_abort", 4'd0);
    reset = 1'b1;
    step_state("sw_dec", 4'd1);
    step_state("sw_madr", 4'd2);
    step_state("sw_mwr", 4'd5);
    check("sw_memw", 32'(MemWrite), 32'd1);
    step_state("sw_done", 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Moore-style multicycle control FSM that sits directly upstream of the MIPS multicycle datapath.
- Consumes the instruction register opcode/funct fields and the ALU zero flag from the datapath.
- Produces every datapath steering and write-enable signal, one state per clock.
- Supported instructions: lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.

Parameters:
- STATE_W, 4, width of the state register and of the state_o debug port.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- Opcode  in  6  instr[31:26] from the IR.
- Funct  in  6  instr[5:0] from the IR.
- Zero  in  1  ALU zero flag (combinational, same cycle as BRANCH).
- PCen  out  1  PC write enable = PCWrite | (Branch & taken).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  data memory write.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- MemtoReg  out  1  write-back source: 0 = ALUOut, 1 = Data.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- PCsrc  out  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- state_o  out  STATE_W  current state encoding (debug/verification).

Behaviour:
- State register:
  - reset==0 at a rising edge loads FETCH.
  - While reset==0, PCen, IRWrite, MemWrite and RegWrite are forced 0 combinationally.
  - All other outputs follow the current state.
  - Reset asserted mid-instruction aborts that instruction; there is no partial write after the edge.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12..15 go to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE by opcode:
    - 0x23 (lw), 0x2B (sw) -> MEMADR.
    - 0x00 -> EXECUTE.
    - 0x04 -> BRANCH.
    - 0x08 -> ADDIEXEC.
    - 0x02 -> JUMP.
    - Any other opcode -> FETCH. Illegal opcodes are skipped as a 2-cycle NOP.
  - MEMADR -> MEMRD for lw, MEMWR for sw.
  - MEMRD -> MEMWB.
  - EXECUTE -> ALUWB.
  - ADDIEXEC -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP -> FETCH.
- Latency in cycles: lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Outputs not listed for a state are 0; ALUControl defaults to 010.
  - FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, add, PCsrc=00, IRWrite=1, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, add.
  - MEMADR / ADDIEXEC: ALUSrcA=1, ALUSrcB=10, add.
  - MEMRD: IorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: IorD=1, MemWrite=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, PCsrc=01, Branch=1, taken=Zero.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCsrc=10, PCWrite=1.
- Funct decode (EXECUTE only): 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111. Any other funct -> 010, and write-back still occurs.
- Opcode and Funct are sampled only in DECODE/MEMADR/EXECUTE. The IR holds them stable because IRWrite is high only in FETCH.

Optional Feature:
- Macro: MIPS_MC_CTRL_BNE_EN.
- Defined: opcode 0x05 (bne) in DECODE -> BRANCH. A registered is_bne flag, latched in DECODE, makes taken = ~Zero.
- Undefined: 0x05 is illegal (DECODE -> FETCH) and taken = Zero always.
- Port list is identical either way.

Decomposition:
- Package mips_mc_pkg:
  - state enum.
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J).
  - funct constants.
  - ALUControl constants.
  - ALUSrcB and PCsrc encodings.
- Sub-module mips_mc_alu_dec: combinational, inputs ALUOp[1:0] + Funct, output ALUControl. ALUOp 00 = add, 01 = sub, 10 = funct decode.

Test Plan:
- Reset hold 3 cycles with Opcode=0x23 -> state_o=0, PCen/IRWrite/MemWrite/RegWrite=0 throughout; first cycle after release PCen=1, IRWrite=1, ALUSrcB=01.
- lw (0x23) -> state_o 0,1,2,3,4,0; MEMRD has IorD=1; MEMWB has RegWrite=1, MemtoReg=1, RegDst=0.
- R-type sub (Funct=0x22), then slt (0x2A) -> EXECUTE ALUControl=110, then 111; ALUWB RegDst=1, RegWrite=1.
- beq with Zero=1 -> BRANCH PCen=1, PCsrc=01; with Zero=0 -> PCen=0; both return to FETCH.
- addi 0x08 -> 0,1,9,10,0 with RegWrite only in state 10. j 0x02 -> PCen=1, PCsrc=10 in state 11. Opcode 0x3F -> 0,1,0.
- reset=0 asserted in MEMWR -> MemWrite=0 that cycle, state_o=0 next. With BNE_EN defined, opcode 0x05 and Zero=0 -> PCen=1; without it, 0x05 -> 0,1,0.
